// File: rtl/rv_pkg.sv
// ============================================================================
// Module      : rv_pkg
// Description : Shared register-file constants and the write-scheduler
//               state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv_pkg;

  localparam int RV_DATA_W   = 32;
  localparam int RV_ADDR_W   = 5;
  localparam int RV_NUM_REGS = 32;

  // INIT clears the file once after reset; RUN serves requesters until the next reset.
  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/regfile_write_scheduler_if.sv
// ============================================================================
// Module      : regfile_write_scheduler_if
// Description : Requester channels (wb / ld / dbg) and register-file write
//               port of the write scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface regfile_write_scheduler_if #(
  parameter int DATA_W = rv_pkg::RV_DATA_W,
  parameter int ADDR_W = rv_pkg::RV_ADDR_W
);

  logic              wb_valid;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              wb_ready;

  logic              ld_valid;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              ld_ready;

  logic              dbg_valid;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_data;
  logic              dbg_ready;

  logic [ADDR_W-1:0] rf_a3;
  logic [DATA_W-1:0] rf_wd3;
  logic              rf_we3;
  logic              init_busy;

  // Request sources / register-file side
  modport master (
    output wb_valid, wb_addr, wb_data,
    output ld_valid, ld_addr, ld_data,
    output dbg_valid, dbg_addr, dbg_data,
    input  wb_ready, ld_ready, dbg_ready,
    input  rf_a3, rf_wd3, rf_we3, init_busy
  );

  // Scheduler side
  modport slave (
    input  wb_valid, wb_addr, wb_data,
    input  ld_valid, ld_addr, ld_data,
    input  dbg_valid, dbg_addr, dbg_data,
    output wb_ready, ld_ready, dbg_ready,
    output rf_a3, rf_wd3, rf_we3, init_busy
  );

endinterface

`default_nettype wire

// File: rtl/rr_arb2.sv
// ============================================================================
// Module      : rr_arb2
// Description : Two-way round-robin arbiter. Bit 0 wins ties when the
//               pointer is 0, bit 1 when it is 1; the pointer flips to the
//               other side after each granted transfer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arb2 (
  input  wire logic       clk,
  input  wire logic       rst,     // asynchronous, active-low
  input  wire logic [1:0] i_req,
  input  wire logic       i_hold,  // forces both grants low
  output logic      [1:0] o_gnt
);

  logic       r_rr;
  logic [1:0] w_xfer;

  // A side is ready when not held and either it owns the tie or the other side is idle.
  assign o_gnt[0] = !i_hold & (!r_rr | !i_req[1]);
  assign o_gnt[1] = !i_hold & ( r_rr | !i_req[0]);
  assign w_xfer   = i_req & o_gnt;

  // Pointer moves away from whichever side just transferred; idle cycles leave it alone.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rr <= 1'b0;
    end else if (w_xfer[0]) begin
      r_rr <= 1'b1;
    end else if (w_xfer[1]) begin
      r_rr <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/regfile_write_scheduler.sv
// ============================================================================
// Module      : regfile_write_scheduler
// Description : Owns the register-file write port. Clears every register
//               after reset, then shares the port among ALU writeback
//               (fixed highest priority), load return and debug (round-robin).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_write_scheduler
  import rv_pkg::*;
#(
  parameter int DATA_W     = RV_DATA_W,
  parameter int ADDR_W     = RV_ADDR_W,
  parameter int NUM_REGS   = RV_NUM_REGS,
  parameter int INIT_CLEAR = 1
) (
  input  wire logic               clk,
  input  wire logic               rst,   // asynchronous, active-low
  regfile_write_scheduler_if.slave bus
);

  localparam state_t            c_RESET_STATE = (INIT_CLEAR != 0) ? INIT : RUN;
  localparam logic [ADDR_W-1:0] c_LAST_IDX    = ADDR_W'(NUM_REGS - 1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_idx;
  logic              r_we3;
  logic [ADDR_W-1:0] r_a3;
  logic [DATA_W-1:0] r_wd3;

  logic [1:0]        w_gnt;
  logic              w_hold;
  logic              w_wb_xfer;
  logic              w_ld_xfer;
  logic              w_dbg_xfer;
  logic              w_sel_vld;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_data;

  // ld/dbg are shut out during the clear sequence and whenever wb is requesting.
  assign w_hold = (r_state != RUN) | bus.wb_valid;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .i_req  ({bus.dbg_valid, bus.ld_valid}),
    .i_hold (w_hold),
    .o_gnt  (w_gnt)
  );

  assign bus.wb_ready  = (r_state == RUN);
  assign bus.ld_ready  = w_gnt[0];
  assign bus.dbg_ready = w_gnt[1];
  assign bus.init_busy = (r_state == INIT);
  assign bus.rf_we3    = r_we3;
  assign bus.rf_a3     = r_a3;
  assign bus.rf_wd3    = r_wd3;

  assign w_wb_xfer  = bus.wb_valid  & bus.wb_ready;
  assign w_ld_xfer  = bus.ld_valid  & bus.ld_ready;
  assign w_dbg_xfer = bus.dbg_valid & bus.dbg_ready;

  // Write mux: pick the single transferring requester, otherwise hold the port values.
  always_comb begin
    w_sel_vld  = 1'b0;
    w_sel_addr = r_a3;
    w_sel_data = r_wd3;
    if (w_wb_xfer) begin
      w_sel_vld  = 1'b1;
      w_sel_addr = bus.wb_addr;
      w_sel_data = bus.wb_data;
    end else if (w_ld_xfer) begin
      w_sel_vld  = 1'b1;
      w_sel_addr = bus.ld_addr;
      w_sel_data = bus.ld_data;
    end else if (w_dbg_xfer) begin
      w_sel_vld  = 1'b1;
      w_sel_addr = bus.dbg_addr;
      w_sel_data = bus.dbg_data;
    end
  end

  // Sequencer: clear registers 0..NUM_REGS-1 in INIT, then register the arbitrated write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= c_RESET_STATE;
      r_idx   <= '0;
      r_we3   <= 1'b0;
      r_a3    <= '0;
      r_wd3   <= '0;
    end else if (r_state == INIT) begin
      r_we3 <= 1'b1;
      r_a3  <= r_idx;
      r_wd3 <= '0;
      r_idx <= r_idx + 1'b1;
      if (r_idx == c_LAST_IDX) begin
        r_state <= RUN;
      end
    end else begin
      // x0 writes are accepted but suppressed so x0 stays zero.
      r_we3 <= w_sel_vld & (w_sel_addr != '0);
      r_a3  <= w_sel_addr;
      r_wd3 <= w_sel_data;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile_write_scheduler.sv
// ============================================================================
// Module      : tb_regfile_write_scheduler
// Description : Directed self-checking bench for regfile_write_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_write_scheduler;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  regfile_write_scheduler_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  regfile_write_scheduler #(
    .DATA_W     (32),
    .ADDR_W     (5),
    .NUM_REGS   (32),
    .INIT_CLEAR (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    bus.wb_valid  = 1'b0; bus.wb_addr  = '0; bus.wb_data  = '0;
    bus.ld_valid  = 1'b0; bus.ld_addr  = '0; bus.ld_data  = '0;
    bus.dbg_valid = 1'b0; bus.dbg_addr = '0; bus.dbg_data = '0;
  endtask

  // Clear sequence seen from just after reset release: 32 writes of zero to 0..31.
  task automatic check_init();
    chk("init_busy_start", 32'(bus.init_busy), 32'd1);
    chk("wb_ready_in_init", 32'(bus.wb_ready), 32'd0);
    for (int k = 0; k < 32; k++) begin
      tick();
      chk($sformatf("init_we3_%0d", k), 32'(bus.rf_we3), 32'd1);
      chk($sformatf("init_a3_%0d", k), 32'(bus.rf_a3), 32'(k));
      chk($sformatf("init_wd3_%0d", k), bus.rf_wd3, 32'd0);
      chk($sformatf("init_busy_%0d", k), 32'(bus.init_busy), (k == 31) ? 32'd0 : 32'd1);
      if (k < 31) chk($sformatf("ld_ready_init_%0d", k), 32'(bus.ld_ready), 32'd0);
    end
    chk("wb_ready_run", 32'(bus.wb_ready), 32'd1);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    clear_reqs();

    // Reset values
    tick();
    tick();
    chk("rst_we3", 32'(bus.rf_we3), 32'd0);
    chk("rst_a3", 32'(bus.rf_a3), 32'd0);
    chk("rst_wd3", bus.rf_wd3, 32'd0);
    chk("rst_busy", 32'(bus.init_busy), 32'd1);
    chk("rst_ld_ready", 32'(bus.ld_ready), 32'd0);

    // 1: clear sequence
    rst = 1'b1;
    check_init();

    // 2: single wb write
    bus.wb_valid = 1'b1; bus.wb_addr = 5'd5; bus.wb_data = 32'hDEADBEEF;
    #1;
    chk("t2_wb_ready", 32'(bus.wb_ready), 32'd1);
    tick();
    bus.wb_valid = 1'b0;
    chk("t2_we3", 32'(bus.rf_we3), 32'd1);
    chk("t2_a3", 32'(bus.rf_a3), 32'd5);
    chk("t2_wd3", bus.rf_wd3, 32'hDEADBEEF);
    tick();
    chk("t2_idle_we3", 32'(bus.rf_we3), 32'd0);
    chk("t2_idle_a3_hold", 32'(bus.rf_a3), 32'd5);
    chk("t2_idle_wd3_hold", bus.rf_wd3, 32'hDEADBEEF);

    // 3: wb, ld, dbg all valid -> wb, ld, dbg on consecutive cycles
    bus.wb_valid  = 1'b1; bus.wb_addr  = 5'd1; bus.wb_data  = 32'h11;
    bus.ld_valid  = 1'b1; bus.ld_addr  = 5'd2; bus.ld_data  = 32'h22;
    bus.dbg_valid = 1'b1; bus.dbg_addr = 5'd3; bus.dbg_data = 32'h33;
    #1;
    chk("t3_c0_wb_ready", 32'(bus.wb_ready), 32'd1);
    chk("t3_c0_ld_ready", 32'(bus.ld_ready), 32'd0);
    chk("t3_c0_dbg_ready", 32'(bus.dbg_ready), 32'd0);
    tick();
    bus.wb_valid = 1'b0;
    chk("t3_wb_a3", 32'(bus.rf_a3), 32'd1);
    chk("t3_wb_wd3", bus.rf_wd3, 32'h11);
    chk("t3_wb_we3", 32'(bus.rf_we3), 32'd1);
    #1;
    chk("t3_c1_ld_ready", 32'(bus.ld_ready), 32'd1);
    chk("t3_c1_dbg_ready", 32'(bus.dbg_ready), 32'd0);
    tick();
    bus.ld_valid = 1'b0;
    chk("t3_ld_a3", 32'(bus.rf_a3), 32'd2);
    chk("t3_ld_wd3", bus.rf_wd3, 32'h22);
    #1;
    chk("t3_c2_dbg_ready", 32'(bus.dbg_ready), 32'd1);
    tick();
    bus.dbg_valid = 1'b0;
    chk("t3_dbg_a3", 32'(bus.rf_a3), 32'd3);
    chk("t3_dbg_wd3", bus.rf_wd3, 32'h33);
    chk("t3_dbg_we3", 32'(bus.rf_we3), 32'd1);

    // 4: ld and dbg continuously valid, rr back at 0 -> ld, dbg, ld, dbg
    bus.ld_valid  = 1'b1; bus.ld_addr  = 5'd7; bus.ld_data  = 32'hAAAA0007;
    bus.dbg_valid = 1'b1; bus.dbg_addr = 5'd9; bus.dbg_data = 32'hBBBB0009;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("t4_ld_ready_%0d", c), 32'(bus.ld_ready), (c % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("t4_dbg_ready_%0d", c), 32'(bus.dbg_ready), (c % 2 == 0) ? 32'd0 : 32'd1);
      tick();
      chk($sformatf("t4_a3_%0d", c), 32'(bus.rf_a3), (c % 2 == 0) ? 32'd7 : 32'd9);
      chk($sformatf("t4_wd3_%0d", c), bus.rf_wd3, (c % 2 == 0) ? 32'hAAAA0007 : 32'hBBBB0009);
    end
    bus.ld_valid  = 1'b0;
    bus.dbg_valid = 1'b0;

    // 5: ld write to x0 is accepted but suppressed
    bus.ld_valid = 1'b1; bus.ld_addr = 5'd0; bus.ld_data = 32'h1234;
    #1;
    chk("t5_ld_ready", 32'(bus.ld_ready), 32'd1);
    tick();
    bus.ld_valid = 1'b0;
    chk("t5_we3", 32'(bus.rf_we3), 32'd0);
    chk("t5_a3", 32'(bus.rf_a3), 32'd0);
    chk("t5_wd3", bus.rf_wd3, 32'h1234);

    // 6: reset in the middle of INIT restarts the clear sequence
    rst = 1'b0;
    tick();
    rst = 1'b1;
    for (int k = 0; k <= 10; k++) tick();
    chk("t6_mid_a3", 32'(bus.rf_a3), 32'd10);
    rst = 1'b0;
    #1;
    chk("t6_async_we3", 32'(bus.rf_we3), 32'd0);
    chk("t6_async_a3", 32'(bus.rf_a3), 32'd0);
    chk("t6_async_busy", 32'(bus.init_busy), 32'd1);
    tick();
    tick();
    rst = 1'b1;
    check_init();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
